// File: rtl/afifo_rd_ptr_empty_if.sv
// Read-side port bundle of the async FIFO pointer/empty stage.
// slave = pointer/empty block, master = consumer driving rd_en and the write Gray pointer.
interface afifo_rd_ptr_empty_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   wr_gray_async;
  logic [ADDR_WIDTH:0]   rd_gray;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  underflow;

  modport master (
    output rd_en, wr_gray_async,
    input  rd_gray, rd_addr, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  rd_en, wr_gray_async,
    output rd_gray, rd_addr, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/afifo_rd_ptr_empty.sv
// Async FIFO read domain: write-pointer synchronizer, read pointer, registered empty/underflow.
// Optional macro AFIFO_RD_COUNT_EN adds the Gray-to-binary converter, rd_count and almost_empty.
module afifo_rd_ptr_empty #(
  parameter int ADDR_WIDTH    = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input logic                 rd_clk,
  input logic                 rd_rst_n,
  afifo_rd_ptr_empty_if.slave rif
);
  localparam int PW = ADDR_WIDTH + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("afifo_rd_ptr_empty: SYNC_STAGES must be in 2..4");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_thresh
    $error("afifo_rd_ptr_empty: AEMPTY_THRESH out of range");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Stage p0: write Gray pointer crossing into rd_clk, plain flop chain
  logic [PW-1:0] wq_p [SYNC_STAGES];
  logic [PW-1:0] wq_sync;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wq_p[i] <= '0;
    end else begin
      wq_p[0] <= rif.wr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) wq_p[i] <= wq_p[i-1];
    end
  end

  assign wq_sync = wq_p[SYNC_STAGES-1];

  // Stage p1: read pointer advance and flag generation
  logic [PW-1:0] rd_bin_p1;
  logic [PW-1:0] rd_gray_p1;
  logic          empty_p1;
  logic          underflow_p1;
  logic          rd_inc;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic          empty_next;

  always_comb begin
    rd_inc       = rif.rd_en & ~empty_p1;
    rd_bin_next  = rd_bin_p1 + {{ADDR_WIDTH{1'b0}}, rd_inc};
    rd_gray_next = bin2gray(rd_bin_next);
    // Full-width compare: the MSB separates "empty" from "full" when the low bits match
    empty_next   = (rd_gray_next == wq_sync);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_p1    <= '0;
      rd_gray_p1   <= '0;
      empty_p1     <= 1'b1;
      underflow_p1 <= 1'b0;
    end else begin
      rd_bin_p1    <= rd_bin_next;
      rd_gray_p1   <= rd_gray_next;
      empty_p1     <= empty_next;
      underflow_p1 <= rif.rd_en & empty_p1;
    end
  end

  assign rif.rd_gray   = rd_gray_p1;
  assign rif.rd_addr   = rd_bin_p1[ADDR_WIDTH-1:0];
  assign rif.empty     = empty_p1;
  assign rif.underflow = underflow_p1;

`ifdef AFIFO_RD_COUNT_EN
  localparam logic [PW:0] AE_TH = AEMPTY_THRESH[PW:0];

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] w_bin_sync;
  logic [PW-1:0] count_next;
  logic          aempty_next;
  logic [PW-1:0] rd_count_p1;
  logic          aempty_p1;

  always_comb begin
    w_bin_sync  = gray2bin(wq_sync);
    // Uses the post-read pointer so the count agrees with empty on the same edge
    count_next  = w_bin_sync - rd_bin_next;
    aempty_next = ({1'b0, count_next} <= AE_TH);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_count_p1 <= '0;
      aempty_p1   <= 1'b1;
    end else begin
      rd_count_p1 <= count_next;
      aempty_p1   <= aempty_next;
    end
  end

  assign rif.rd_count     = rd_count_p1;
  assign rif.almost_empty = aempty_p1;
`else
  assign rif.rd_count     = '0;
  assign rif.almost_empty = empty_p1;
`endif

endmodule

// File: tb/tb_afifo_rd_ptr_empty.sv
// Bench for afifo_rd_ptr_empty: directed vector table, corner sequences and a randomized run
// checked against an integer-pointer reference model.
module tb_afifo_rd_ptr_empty;
  localparam int SS    = 2;
  localparam int DEPTH = 32;
  localparam int TH    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  afifo_rd_ptr_empty_if #(.ADDR_WIDTH(5)) rif ();

  afifo_rd_ptr_empty #(.ADDR_WIDTH(5), .SYNC_STAGES(SS), .AEMPTY_THRESH(TH)) dut (
    .rd_clk   (clk),
    .rd_rst_n (rst_n),
    .rif      (rif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_ptr  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] g6(input int v);
    logic [5:0] b;
    b = v[5:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef AFIFO_RD_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_ae(input bit ae, input bit e);
`ifdef AFIFO_RD_COUNT_EN
    return ae;
`else
    return e;
`endif
  endfunction

  task automatic set_w(input int w);
    wr_ptr = w;
    rif.wr_gray_async = g6(w);
  endtask

  task automatic step(input bit en, input int w);
    @(negedge clk);
    rif.rd_en = en;
    set_w(w);
    @(posedge clk);
    #1;
  endtask

  // Reference model: absolute word counts; the read domain sees the write count SS edges late
  int q_hist[$];
  int m_rd;
  int m_count;
  int m_seen;
  bit m_empty;
  bit m_uf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_hist = {};
      for (int i = 0; i < SS; i++) q_hist.push_back(0);
      m_rd = 0; m_count = 0; m_empty = 1'b1; m_uf = 1'b0;
    end else begin
      q_hist.push_back(wr_ptr);
      m_seen  = q_hist.pop_front();
      m_uf    = rif.rd_en && m_empty;
      if (rif.rd_en && !m_empty) m_rd++;
      m_count = m_seen - m_rd;
      m_empty = (m_count == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_empty", rif.empty, m_empty);
      chk("model_aempty", rif.almost_empty, exp_ae(m_count <= TH, m_empty));
      chk("model_count", rif.rd_count, exp_cnt(m_count));
      chk("model_gray", rif.rd_gray, g6(m_rd));
      chk("model_addr", rif.rd_addr, m_rd % DEPTH);
      chk("model_uf", rif.underflow, m_uf);
    end
  end

  typedef struct {
    bit         en;
    int         w;
    bit         e;
    bit         ae;
    int         addr;
    logic [5:0] gray;
    bit         uf;
    int         cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] prev_g;
    bit         saw_32, saw_0;
    int         k, base;

    tbl[0]  = '{1, 0, 1, 1, 0, 6'd0, 1, 0};
    tbl[1]  = '{1, 0, 1, 1, 0, 6'd0, 1, 0};
    tbl[2]  = '{0, 1, 1, 1, 0, 6'd0, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 6'd0, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 6'd0, 0, 1};
    tbl[5]  = '{1, 1, 1, 1, 1, 6'd1, 0, 0};
    tbl[6]  = '{1, 1, 1, 1, 1, 6'd1, 1, 0};
    tbl[7]  = '{0, 2, 1, 1, 1, 6'd1, 0, 0};
    tbl[8]  = '{0, 2, 1, 1, 1, 6'd1, 0, 0};
    tbl[9]  = '{0, 2, 0, 1, 1, 6'd1, 0, 1};
    tbl[10] = '{0, 3, 0, 1, 1, 6'd1, 0, 1};
    tbl[11] = '{0, 3, 0, 1, 1, 6'd1, 0, 1};
    tbl[12] = '{1, 3, 0, 1, 2, 6'd3, 0, 1};
    tbl[13] = '{1, 3, 1, 1, 3, 6'd2, 0, 0};

    rif.rd_en = 1'b1;
    set_w(0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_empty", rif.empty, 1);
    chk("rst_aempty", rif.almost_empty, 1);
    chk("rst_gray", rif.rd_gray, 0);
    chk("rst_uf", rif.underflow, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, starting on the release edge
    for (int i = 0; i < 14; i++) begin
      rif.rd_en = tbl[i].en;
      set_w(tbl[i].w);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_empty", i), rif.empty, tbl[i].e);
      chk($sformatf("vec%0d_aempty", i), rif.almost_empty, exp_ae(tbl[i].ae, tbl[i].e));
      chk($sformatf("vec%0d_addr", i), rif.rd_addr, tbl[i].addr);
      chk($sformatf("vec%0d_gray", i), rif.rd_gray, tbl[i].gray);
      chk($sformatf("vec%0d_uf", i), rif.underflow, tbl[i].uf);
      chk($sformatf("vec%0d_cnt", i), rif.rd_count, exp_cnt(tbl[i].cnt));
      @(negedge clk);
    end

    // Eight words, one read per cycle: almost_empty at count 4, empty after the 8th read
    base = wr_ptr;
    repeat (SS + 1) step(0, base + 8);
    chk("w8_empty", rif.empty, 0);
    chk("w8_cnt", rif.rd_count, exp_cnt(8));
    chk("w8_aempty", rif.almost_empty, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, base + 8);
      chk($sformatf("w8_rd%0d_empty", i), rif.empty, i == 8);
      chk($sformatf("w8_rd%0d_aempty", i), rif.almost_empty, exp_ae((8 - i) <= TH, i == 8));
      chk($sformatf("w8_rd%0d_cnt", i), rif.rd_count, exp_cnt(8 - i));
    end

    // Stream through both pointer wraps with the writer ahead
    saw_32 = 0; saw_0 = 0;
    k = 0;
    while (m_rd < 70 && k < 300) begin
      prev_g = rif.rd_gray;
      step(1, (wr_ptr - m_rd < DEPTH) ? wr_ptr + 1 : wr_ptr);
      chk("wrap_onebit", ($countones(prev_g ^ rif.rd_gray) <= 1), 1);
      if (prev_g == 6'b010000 && rif.rd_gray == 6'b110000 && rif.rd_addr == 0) saw_32 = 1;
      if (prev_g == 6'b100000 && rif.rd_gray == 6'b000000 && rif.rd_addr == 0) saw_0 = 1;
      k++;
    end
    chk("wrap_budget", k < 300, 1);
    chk("wrap_31_to_32", saw_32, 1);
    chk("wrap_63_to_0", saw_0, 1);
    k = 0;
    while (!rif.empty && k < 100) begin step(1, wr_ptr); k++; end
    chk("wrap_drained", rif.empty, 1);

    // Full: writer exactly one depth ahead (MSB differs, low bits equal)
    base = m_rd;
    repeat (SS + 1) step(0, base + DEPTH);
    chk("full_empty", rif.empty, 0);
    chk("full_cnt", rif.rd_count, exp_cnt(DEPTH));
    chk("full_aempty", rif.almost_empty, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, base + DEPTH);
      chk($sformatf("full_rd%0d_empty", i), rif.empty, i == DEPTH);
    end

    // Randomized phases with different read/write rates
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        bit en, wr;
        en = ($urandom_range(0, 3) < ((ph == 1) ? 1 : 3));
        wr = ($urandom_range(0, 3) < ((ph == 2) ? 1 : 3));
        step(en, (wr && (wr_ptr - m_rd < DEPTH)) ? wr_ptr + 1 : wr_ptr);
      end
    end

    // Reset asserted mid-stream with ten words held
    k = 0;
    while (!rif.empty && k < 100) begin step(1, wr_ptr); k++; end
    base = m_rd;
    repeat (SS + 1) step(0, base + 10);
    chk("pre_rst_cnt", rif.rd_count, exp_cnt(10));
    chk("pre_rst_empty", rif.empty, 0);
    @(negedge clk);
    rif.rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", rif.empty, 1);
    chk("arst_aempty", rif.almost_empty, 1);
    chk("arst_cnt", rif.rd_count, 0);
    chk("arst_gray", rif.rd_gray, 0);
    chk("arst_addr", rif.rd_addr, 0);
    chk("arst_uf", rif.underflow, 0);
    set_w(0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_uf", rif.underflow, 0);
    chk("arst_hold_empty", rif.empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0);
    chk("rel_uf", rif.underflow, 1);
    chk("rel_empty", rif.empty, 1);
    step(1, 0);
    chk("rel_uf2", rif.underflow, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/afifo_rd_ptr_empty.md
Name: afifo_rd_ptr_empty

Overview:
- Read-domain pointer and empty-flag stage of the asynchronous FIFO.
- Synchronizes the write-side Gray pointer into the read clock domain and converts it to binary with the Gray-to-binary converter stage.
- Maintains the read pointer in binary and Gray, generates the registered empty / almost_empty flags and the fill count.
- Drives the RAM read address and exports the read Gray pointer to the write domain.

Parameters:
- ADDR_WIDTH, 5, RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (6 by default).
- SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; legal values 2..4.
- AEMPTY_THRESH, 4, almost_empty asserts when the fill count is <= this value.

Ports:
- rd_clk, input, 1, read-domain clock.
- rd_rst_n, input, 1, asynchronous active-low reset.
- rd_en, input, 1, read request from the consumer.
- wr_gray_async, input, ADDR_WIDTH+1, write pointer in Gray code, launched from the write clock domain.
- rd_gray, output, ADDR_WIDTH+1, registered read pointer in Gray code, sent to the write-domain synchronizer.
- rd_addr, output, ADDR_WIDTH, RAM read address = rd_bin[ADDR_WIDTH-1:0].
- empty, output, 1, registered empty flag.
- almost_empty, output, 1, registered; fill count <= AEMPTY_THRESH.
- rd_count, output, ADDR_WIDTH+1, registered fill count as seen by the read domain.
- underflow, output, 1, one-cycle pulse on a read attempt while empty.

Behaviour:
- Reset (async assert, sync release on rd_clk):
  - all synchronizer flops, rd_bin, rd_gray, rd_count = 0.
  - empty = 1, almost_empty = 1, underflow = 0.
- Synchronizer:
  - wr_gray_async passes through SYNC_STAGES flops to give wq_sync.
  - No logic between the stages.
  - wq_sync feeds the Gray-to-binary converter (combinational), giving w_bin_sync.
- Read increment:
  - rd_inc = rd_en & ~empty.
  - rd_bin_next = rd_bin + rd_inc, modulo 2**(ADDR_WIDTH+1), so the pointer wraps from 63 to 0.
  - rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next.
  - Both pointers are registered every cycle; rd_gray changes at most one bit per cycle.
- Empty:
  - empty <= (rd_gray_next == wq_sync), i.e. the full-width Gray compare including the MSB.
  - The read that drains the last word sets empty on the same clock edge that consumes it.
- Count:
  - rd_count <= (w_bin_sync - rd_bin_next) modulo 2**(ADDR_WIDTH+1).
  - Range is 0..2**ADDR_WIDTH.
- Almost empty: almost_empty <= (count_next <= AEMPTY_THRESH).
- Underflow:
  - underflow <= rd_en & empty.
  - Pointers do not move on an underflow.
  - Consecutive blocked reads give consecutive pulses.
- Latency:
  - A write-pointer change reaches empty / rd_count after SYNC_STAGES+1 rd_clk edges.
  - A read changes rd_addr and rd_gray on the next edge.
- Conservatism: empty may stay asserted late (synchronizer lag) but never deasserts while the FIFO is truly empty.
- Simultaneous read and a new write-pointer arrival: both terms enter the same rd_gray_next / wq_sync compare. A read of the last old word with one new word arriving leaves empty = 0 and rd_count = 1.
- Reset mid-operation: all state returns to reset values immediately, including the synchronizer. The write domain must also be reset; no partial recovery is defined.

Optional Feature:
- Macro AFIFO_RD_COUNT_EN.
- Defined: rd_count and almost_empty are generated as above, and the converter instance is present.
- Undefined:
  - Converter and subtractor are omitted.
  - rd_count is tied to 0.
  - almost_empty is driven identically to empty.
  - Empty/pointer/underflow behaviour is unchanged.

Test Plan:
- Reset release with wr_gray_async=0 and rd_en=1 held -> empty=1, rd_gray=0, rd_addr=0, underflow pulses each cycle from the first edge after release.
- Drive wr_gray_async=6'b000001 (one word) -> empty falls and rd_count=1 exactly 3 edges later (SYNC_STAGES=2). One rd_en cycle then gives rd_addr=1, rd_gray=6'b000001, empty=1, rd_count=0 on the same edge.
- Step the write pointer to binary 8 (Gray 6'b001100) and read one word per cycle -> almost_empty rises when rd_count reaches 4; empty rises after the 8th read.
- Wrap-around, with the write pointer ahead -> rd_bin goes 31 -> 32 (rd_gray 6'b010000 -> 6'b110000, rd_addr 31 -> 0) and later 63 -> 0 (6'b100000 -> 6'b000000). Each step changes exactly one Gray bit and empty matches only on the full 6-bit equality.
- Full FIFO: write pointer = read pointer + 32 (MSB differs, lower bits equal) -> empty=0, rd_count=32; 32 reads drain it to empty=1.
- Assert rd_rst_n low mid-stream with rd_count=10 -> outputs go to reset values without waiting for a clock edge; no underflow pulse is generated.
